// File: rtl/storage_bank.sv
// Switch-captured register file: edge-detected write/clear keys, multi-cycle clear sweep,
// registered LED readback with write-through bypass. Optional auto-scan display: STORAGE_SCAN_EN.
module storage_bank #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_write,
    input  logic              key_clear,
    input  logic              scan_mode,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_value,
    output logic [DATA_W-1:0] ledr_indic,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              busy,
    output logic              wr_ack
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic              key_write_q, key_clear_q;
    logic              write_fire, clear_fire;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              ack_next;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    assign write_fire = key_write & ~key_write_q;
    assign clear_fire = key_clear & ~key_clear_q;

    // Key history resets to 1 so a key held through reset cannot fire on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            key_write_q <= 1'b1;
            key_clear_q <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            key_write_q <= key_write;
            key_clear_q <= key_clear;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (clear_fire) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear beats a simultaneous write; key fires during the sweep are discarded.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sw_addr;
        mem_wdata = sw_value;
        ack_next  = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (write_fire && !clear_fire) begin
                    mem_we   = 1'b1;
                    ack_next = 1'b1;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = '0;
            end
            default: ;
        endcase
    end

`ifdef STORAGE_SCAN_EN
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRE_W-1:0]  scan_pre;
    logic [ADDR_W-1:0] scan_ptr;

    always_ff @(posedge clk) begin
        if (rst || !scan_mode) begin
            scan_pre <= '0;
            scan_ptr <= '0;
        end else if (scan_pre == PRE_W'(SCAN_DIV - 1)) begin
            scan_pre <= '0;
            scan_ptr <= scan_ptr + 1'b1;
        end else begin
            scan_pre <= scan_pre + 1'b1;
        end
    end

    assign rd_addr = scan_mode ? scan_ptr : sw_addr;
`else
    logic unused_scan_mode;
    assign unused_scan_mode = scan_mode;
    assign rd_addr          = sw_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
            ledr_indic <= '0;
            disp_addr  <= '0;
            wr_ack     <= 1'b0;
        end else begin
            if (mem_we) begin
                mem[mem_waddr] <= mem_wdata;
            end
            ledr_indic <= (mem_we && (mem_waddr == rd_addr)) ? mem_wdata : mem[rd_addr];
            disp_addr  <= rd_addr;
            wr_ack     <= ack_next;
        end
    end

endmodule

// File: tb/tb_storage_bank.sv
// Directed self-checking bench for storage_bank (DATA_W=8, ADDR_W=3, SCAN_DIV=4).
module tb_storage_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_write;
    logic       key_clear;
    logic       scan_mode;
    logic [2:0] sw_addr;
    logic [7:0] sw_value;
    logic [7:0] ledr_indic;
    logic [2:0] disp_addr;
    logic       busy;
    logic       wr_ack;

    int checks = 0;
    int errors = 0;

    storage_bank #(.DATA_W(8), .ADDR_W(3), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_write  (key_write),
        .key_clear  (key_clear),
        .scan_mode  (scan_mode),
        .sw_addr    (sw_addr),
        .sw_value   (sw_value),
        .ledr_indic (ledr_indic),
        .disp_addr  (disp_addr),
        .busy       (busy),
        .wr_ack     (wr_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One key press: ack and bypassed LED value right after the fire edge, ack gone next cycle.
    task automatic press_write(input logic [2:0] a, input logic [7:0] v);
        sw_addr   = a;
        sw_value  = v;
        key_write = 1'b1;
        @(negedge clk);
        chk("wr_ack_pulse", wr_ack, 1);
        chk("wr_bypass", ledr_indic, v);
        key_write = 1'b0;
        @(negedge clk);
        chk("wr_ack_end", wr_ack, 0);
    endtask

    task automatic show(input logic [2:0] a, input logic [7:0] v);
        sw_addr = a;
        @(negedge clk);
        chk("disp_addr", disp_addr, a);
        chk("ledr_read", ledr_indic, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nbusy;
        int nack;
        logic [7:0] exp_scan [8];

        rst = 1'b1; key_write = 1'b0; key_clear = 1'b0; scan_mode = 1'b0;
        sw_addr = 3'd4; sw_value = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ledr", ledr_indic, 0);
        chk("rst_disp", disp_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", wr_ack, 0);
        rst = 1'b0;
        @(negedge clk);

        // Five writes and readback.
        press_write(3'd0, 8'd10);
        press_write(3'd1, 8'd20);
        press_write(3'd2, 8'd30);
        press_write(3'd3, 8'd40);
        press_write(3'd4, 8'd50);
        show(3'd0, 8'd10);
        show(3'd1, 8'd20);
        show(3'd2, 8'd30);
        show(3'd3, 8'd40);
        show(3'd4, 8'd50);
        show(3'd5, 8'd0);

        // Held key: one write, value captured at the rising edge only.
        sw_addr = 3'd2; sw_value = 8'd77; key_write = 1'b1;
        nack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_ack) nack++;
            if (i == 4) sw_value = 8'd99;
        end
        key_write = 1'b0;
        @(negedge clk);
        if (wr_ack) nack++;
        chk("held_ack_count", nack, 1);
        show(3'd2, 8'd77);

        // Write-through bypass on the displayed address.
        show(3'd3, 8'd40);
        press_write(3'd3, 8'hAA);
        show(3'd3, 8'hAA);

        // Clear sweep with a write press in the middle of it.
        key_clear = 1'b1;
        nbusy = 0; nack = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (wr_ack) nack++;
            if (i == 2) key_write = 1'b1;
            if (i == 3) key_clear = 1'b0;
            if (i == 4) key_write = 1'b0;
        end
        chk("clear_busy_cycles", nbusy, 8);
        chk("clear_write_ignored", nack, 0);
        for (int a = 0; a < 8; a++) show(3'(a), 8'd0);

        // Simultaneous clear and write: clear wins.
        press_write(3'd1, 8'h55);
        sw_addr = 3'd1; sw_value = 8'h66;
        key_clear = 1'b1; key_write = 1'b1;
        nbusy = 0; nack = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (wr_ack) nack++;
            if (i == 3) begin
                key_clear = 1'b0;
                key_write = 1'b0;
            end
        end
        chk("simul_busy_cycles", nbusy, 8);
        chk("simul_no_ack", nack, 0);
        show(3'd1, 8'd0);

        // Reset mid-sweep with key_write held through reset.
        press_write(3'd6, 8'h11);
        key_clear = 1'b1;
        @(negedge clk);
        key_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midsweep_busy", busy, 1);
        rst = 1'b1; key_write = 1'b1; sw_addr = 3'd6; sw_value = 8'h22;
        @(negedge clk);
        chk("rst_sweep_busy", busy, 0);
        chk("rst_sweep_ledr", ledr_indic, 0);
        chk("rst_sweep_disp", disp_addr, 0);
        chk("rst_sweep_ack", wr_ack, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_through_rst_no_ack", wr_ack, 0);
        end
        chk("held_through_rst_mem", ledr_indic, 0);
        key_write = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        press_write(3'd6, 8'h22);
        show(3'd6, 8'h22);

`ifdef STORAGE_SCAN_EN
        do_reset();
        press_write(3'd0, 8'd10);
        press_write(3'd1, 8'd20);
        press_write(3'd2, 8'd30);
        press_write(3'd3, 8'd40);
        press_write(3'd4, 8'd50);
        exp_scan = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0, 8'd0};
        sw_addr   = 3'd6;
        scan_mode = 1'b1;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            chk("scan_disp", disp_addr, 32'((k / 4) % 8));
            chk("scan_ledr", ledr_indic, exp_scan[(k / 4) % 8]);
        end
        scan_mode = 1'b0;
        show(3'd3, 8'd40);
`else
        // Without the scan feature scan_mode must have no effect.
        scan_mode = 1'b1;
        show(3'd6, 8'h22);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("scan_ignored_disp", disp_addr, 6);
        scan_mode = 1'b0;
        do_reset();
        show(3'd6, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
